// File: rtl/ascon_cmd_sequencer_pkg.sv
// Shared Ascon sequencer definitions: opcodes, data types, widths, states.
// Used by ascon_cmd_sequencer (optional stats via ASCON_SEQ_STATS_EN).
package ascon_cmd_sequencer_pkg;

  localparam int CCW  = 32;
  localparam int CCSW = 32;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_LD_KEY   = 4'h1;
  localparam logic [3:0] OP_LD_NONCE = 4'h2;
  localparam logic [3:0] OP_LD_AD    = 4'h3;
  localparam logic [3:0] OP_LD_PT    = 4'h4;
  localparam logic [3:0] OP_LD_CT    = 4'h5;
  localparam logic [3:0] OP_LD_TAG   = 4'h6;
  localparam logic [3:0] OP_DO_ENC   = 4'h7;
  localparam logic [3:0] OP_DO_DEC   = 4'h8;
  localparam logic [3:0] OP_DO_HASH  = 4'h9;

  localparam logic [3:0] D_NULL  = 4'h0;
  localparam logic [3:0] D_NONCE = 4'h1;
  localparam logic [3:0] D_AD    = 4'h2;
  localparam logic [3:0] D_PTCT  = 4'h3;
  localparam logic [3:0] D_TAG   = 4'h4;
  localparam logic [3:0] D_HASH  = 4'h5;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE      = 2'd0;
  localparam seq_state_t ST_KEY       = 2'd1;
  localparam seq_state_t ST_BDI       = 2'd2;
  localparam seq_state_t ST_WAIT_AUTH = 2'd3;

  function automatic logic [3:0] op2bdi_type(input logic [3:0] op);
    logic [3:0] t;
    unique case (op)
      OP_LD_NONCE:         t = D_NONCE;
      OP_LD_AD:            t = D_AD;
      OP_LD_PT, OP_LD_CT:  t = D_PTCT;
      OP_LD_TAG:           t = D_TAG;
      default:             t = D_NULL;
    endcase
    return t;
  endfunction

  function automatic logic is_bdi_op(input logic [3:0] op);
    return (op == OP_LD_NONCE) || (op == OP_LD_AD) ||
           (op == OP_LD_PT) || (op == OP_LD_CT) ||
           (op == OP_LD_TAG);
  endfunction

endpackage

// File: rtl/ascon_cmd_sequencer_if.sv
// Command stream, core key/bdi/bdo/auth and mode/status signals.
// Shared by ascon_cmd_sequencer (slave) and its driver (master).
interface ascon_cmd_sequencer_if;
  import ascon_cmd_sequencer_pkg::*;

  logic [31:0]     cmd_data;
  logic            cmd_is_ins;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [CCSW-1:0] key;
  logic            key_valid;
  logic            key_ready;
  logic [CCW-1:0]  bdi;
  logic            bdi_valid;
  logic            bdi_ready;
  logic [3:0]      bdi_type;
  logic            bdi_eot;
  logic            bdi_eoi;
  logic            decrypt;
  logic            hash;
  logic            bdo_valid;
  logic [3:0]      bdo_type;
  logic            bdo_ready;
  logic            auth_valid;
  logic            auth_ready;
  logic            proto_err;

  modport slave (
    input  cmd_data, cmd_is_ins, cmd_valid,
    input  key_ready, bdi_ready,
    input  bdo_valid, bdo_type, auth_valid,
    output cmd_ready, key, key_valid,
    output bdi, bdi_valid, bdi_type,
    output bdi_eot, bdi_eoi,
    output decrypt, hash,
    output bdo_ready, auth_ready, proto_err
  );

  modport master (
    output cmd_data, cmd_is_ins, cmd_valid,
    output key_ready, bdi_ready,
    output bdo_valid, bdo_type, auth_valid,
    input  cmd_ready, key, key_valid,
    input  bdi, bdi_valid, bdi_type,
    input  bdi_eot, bdi_eoi,
    input  decrypt, hash,
    input  bdo_ready, auth_ready, proto_err
  );

endinterface

// File: rtl/ascon_seq_stats.sv
// Wrapping handshake counters for the sequencer.
// Instantiated only when ASCON_SEQ_STATS_EN is defined.
module ascon_seq_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        ins_hs_i,
  input  logic        dat_hs_i,
  output logic [15:0] stat_ins_o,
  output logic [15:0] stat_dat_o
);

  logic [15:0] ins_q, ins_d;
  logic [15:0] dat_q, dat_d;

  // next counts, wrapping naturally
  always_comb begin
    ins_d = ins_q + {15'd0, ins_hs_i};
    dat_d = dat_q + {15'd0, dat_hs_i};
  end

  // counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_q <= '0;
      dat_q <= '0;
    end else begin
      ins_q <= ins_d;
      dat_q <= dat_d;
    end
  end

  assign stat_ins_o = ins_q;
  assign stat_dat_o = dat_q;

endmodule

// File: rtl/ascon_cmd_sequencer.sv
// INS/DAT command stream to ascon_core key/bdi front end.
// Define ASCON_SEQ_STATS_EN to add stat_ins/stat_dat counters.
module ascon_cmd_sequencer
  import ascon_cmd_sequencer_pkg::*;
#(
  parameter int LEN_W = 24,
  parameter int CNT_W = 22
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ASCON_SEQ_STATS_EN
  output logic [15:0] stat_ins,
  output logic [15:0] stat_dat,
`endif
  ascon_cmd_sequencer_if.slave bus
);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_ld, cnt_dec;
  logic [LEN_W:0]   len_p3;
  logic [3:0]       op_q, op_d;
  logic             eoi_q, eoi_d;
  logic             dec_q, dec_d;
  logic             hash_q, hash_d;
  logic             perr_q, perr_d;
  logic             cmd_rdy;
  logic             hs;
  logic [3:0]       ins_op;

  assign ins_op  = bus.cmd_data[31:28];
  assign len_p3  = {1'b0, bus.cmd_data[LEN_W-1:0]}
                 + (LEN_W+1)'(3);
  assign cnt_ld  = CNT_W'(len_p3 >> 2);
  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
  assign hs      = bus.cmd_valid & cmd_rdy;

  // pass-through datapath and handshake outputs, all low in reset
  always_comb begin
    cmd_rdy       = 1'b0;
    bus.key       = '0;
    bus.key_valid = 1'b0;
    bus.bdi       = '0;
    bus.bdi_valid = 1'b0;
    bus.bdi_type  = D_NULL;
    bus.bdi_eot   = 1'b0;
    bus.bdi_eoi   = 1'b0;
    bus.auth_ready = 1'b0;
    bus.bdo_ready = 1'b0;
    if (!rst) begin
      bus.bdo_ready = bus.bdo_valid &&
        (bus.bdo_type == D_TAG || bus.bdo_type == D_HASH);
      unique case (state_q)
        ST_IDLE: cmd_rdy = 1'b1;
        ST_KEY: begin
          bus.key       = bus.cmd_data;
          bus.key_valid = bus.cmd_valid & ~bus.cmd_is_ins;
          cmd_rdy       = bus.key_ready & ~bus.cmd_is_ins;
        end
        ST_BDI: begin
          bus.bdi       = bus.cmd_data;
          bus.bdi_valid = bus.cmd_valid & ~bus.cmd_is_ins;
          cmd_rdy       = bus.bdi_ready & ~bus.cmd_is_ins;
          bus.bdi_type  = op2bdi_type(op_q);
          bus.bdi_eot   = (cnt_q == CNT_W'(1));
          bus.bdi_eoi   = (cnt_q == CNT_W'(1)) & eoi_q;
          if (op_q == OP_LD_PT || op_q == OP_LD_CT)
            bus.bdo_ready = 1'b1;
        end
        ST_WAIT_AUTH: bus.auth_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_rdy;
  assign bus.decrypt   = dec_q;
  assign bus.hash      = hash_q;
  assign bus.proto_err = perr_q;

  // instruction decode, word counting and state transitions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    eoi_d   = eoi_q;
    dec_d   = dec_q;
    hash_d  = hash_q;
    perr_d  = perr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hs && !bus.cmd_is_ins) begin
          perr_d = 1'b1;
        end else if (hs) begin
          op_d  = ins_op;
          eoi_d = bus.cmd_data[24];
          cnt_d = cnt_ld;
          unique case (1'b1)
            (ins_op == OP_DO_ENC): begin
              dec_d  = 1'b0;
              hash_d = 1'b0;
            end
            (ins_op == OP_DO_DEC): begin
              dec_d  = 1'b1;
              hash_d = 1'b0;
            end
            (ins_op == OP_DO_HASH): begin
              dec_d  = 1'b0;
              hash_d = 1'b1;
            end
            (ins_op == OP_LD_KEY): begin
              if (cnt_ld != '0) state_d = ST_KEY;
            end
            is_bdi_op(ins_op): begin
              if (cnt_ld != '0) state_d = ST_BDI;
            end
            default: ;
          endcase
        end
      end
      ST_KEY, ST_BDI: begin
        if (bus.cmd_valid && bus.cmd_is_ins)
          perr_d = 1'b1;
        if (hs) begin
          cnt_d = cnt_dec;
          if (cnt_q <= CNT_W'(1))
            state_d = (state_q == ST_BDI &&
                       op_q == OP_LD_TAG) ?
                      ST_WAIT_AUTH : ST_IDLE;
        end
      end
      ST_WAIT_AUTH: begin
        if (bus.auth_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      eoi_q   <= 1'b0;
      dec_q   <= 1'b0;
      hash_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      eoi_q   <= eoi_d;
      dec_q   <= dec_d;
      hash_q  <= hash_d;
      perr_q  <= perr_d;
    end
  end

`ifdef ASCON_SEQ_STATS_EN
  logic ins_hs, dat_hs;
  assign ins_hs = hs & bus.cmd_is_ins;
  assign dat_hs = hs & ~bus.cmd_is_ins &
                  (state_q != ST_IDLE);

  ascon_seq_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .ins_hs_i   (ins_hs),
    .dat_hs_i   (dat_hs),
    .stat_ins_o (stat_ins),
    .stat_dat_o (stat_dat)
  );
`endif

endmodule

// File: tb/tb_ascon_cmd_sequencer.sv
// Randomized self-checking bench for ascon_cmd_sequencer.
// Builds with or without ASCON_SEQ_STATS_EN.
module tb_ascon_cmd_sequencer;
  import ascon_cmd_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ascon_cmd_sequencer_if bus();

`ifdef ASCON_SEQ_STATS_EN
  logic [15:0] stat_ins, stat_dat;
`endif

  ascon_cmd_sequencer #(.LEN_W(24), .CNT_W(22)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef ASCON_SEQ_STATS_EN
    .stat_ins (stat_ins),
    .stat_dat (stat_dat),
`endif
    .bus      (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int rdy_mode = 0;
  bit mirror_chk = 0;
  logic mdl_dec = 0;
  logic mdl_hash = 0;
  logic [31:0] key_q[$];
  logic [37:0] bdi_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.key_valid && bus.key_ready)
        key_q.push_back(bus.key);
      if (bus.bdi_valid && bus.bdi_ready)
        bdi_q.push_back({bus.bdi_type, bus.bdi_eot,
                         bus.bdi_eoi, bus.bdi});
    end
  end

  function automatic logic [3:0] exp_type(input logic [3:0] op);
    case (op)
      OP_LD_NONCE:        return D_NONCE;
      OP_LD_AD:           return D_AD;
      OP_LD_PT, OP_LD_CT: return D_PTCT;
      OP_LD_TAG:          return D_TAG;
      default:            return D_NULL;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input bit ins, input logic [31:0] d,
                            input int maxc, output bit ok);
    bit smp;
    ok = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_is_ins = ins;
    bus.cmd_data = d;
    for (int c = 0; c < maxc; c++) begin
      if (rdy_mode == 1) begin
        bus.key_ready = 1'($urandom_range(0, 1));
        bus.bdi_ready = 1'($urandom_range(0, 1));
      end else if (rdy_mode == 2) begin
        bus.bdi_ready = ~bus.bdi_ready;
      end
      @(negedge clk);
      smp = bus.cmd_ready;
      if (mirror_chk && !ins) begin
        n_chk++;
        if (bus.cmd_ready !== bus.bdi_ready) begin
          n_err++;
          $display("FAIL mirror: cmd_ready=%b bdi_ready=%b",
                   bus.cmd_ready, bus.bdi_ready);
        end
      end
      tick();
      if (smp) begin
        ok = 1;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_is_ins = 1'b0;
  endtask

  task automatic run_load(input logic [3:0] op,
                          input logic [3:0] fl, input int len);
    bit ok;
    int n;
    bit is_ld;
    logic [31:0] d;
    logic [31:0] exp_k[$];
    logic [37:0] exp_b[$];
    is_ld = (op == OP_LD_KEY) || (exp_type(op) != D_NULL);
    n = is_ld ? (len + 3) / 4 : 0;
    key_q.delete();
    bdi_q.delete();
    drive_word(1'b1, {op, fl, 24'(len)}, 20, ok);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL ins_accept: op=%0d got no handshake, need one", op);
    end
    if (op == OP_DO_ENC) begin mdl_dec = 0; mdl_hash = 0; end
    if (op == OP_DO_DEC) begin mdl_dec = 1; mdl_hash = 0; end
    if (op == OP_DO_HASH) begin mdl_dec = 0; mdl_hash = 1; end
    if (n > 0) begin
      @(negedge clk);
      n_chk++;
      if (bus.bdo_ready !== (op == OP_LD_PT || op == OP_LD_CT)) begin
        n_err++;
        $display("FAIL bdo_ready_phase: op=%0d got %b", op,
                 bus.bdo_ready);
      end
      tick();
    end
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      drive_word(1'b0, d, 60, ok);
      n_chk++;
      if (!ok) begin
        n_err++;
        $display("FAIL dat_accept: word %0d not taken", i);
      end
      if (op == OP_LD_KEY) exp_k.push_back(d);
      else exp_b.push_back({exp_type(op), 1'(i == n - 1),
                            1'((i == n - 1) && fl[0]), d});
    end
    n_chk++;
    if (key_q.size() != exp_k.size() || bdi_q.size() != exp_b.size()) begin
      n_err++;
      $display("FAIL xfer_count: key %0d/%0d bdi %0d/%0d (got/need)",
               key_q.size(), exp_k.size(), bdi_q.size(), exp_b.size());
    end
    foreach (exp_k[i]) begin
      n_chk++;
      if (key_q[i] !== exp_k[i]) begin
        n_err++;
        $display("FAIL key_word[%0d]: got %h need %h", i, key_q[i],
                 exp_k[i]);
      end
    end
    foreach (exp_b[i]) begin
      n_chk++;
      if (bdi_q[i] !== exp_b[i]) begin
        n_err++;
        $display("FAIL bdi_word[%0d]: got %h need %h", i, bdi_q[i],
                 exp_b[i]);
      end
    end
    if (op == OP_LD_TAG && n > 0) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        @(negedge clk);
        n_chk++;
        if ({bus.auth_ready, bus.cmd_ready} !== 2'b10) begin
          n_err++;
          $display("FAIL auth_wait: auth_ready,cmd_ready=%b%b need 10",
                   bus.auth_ready, bus.cmd_ready);
        end
        tick();
      end
      bus.auth_valid = 1'b1;
      @(negedge clk);
      n_chk++;
      if (bus.auth_ready !== 1'b1) begin
        n_err++;
        $display("FAIL auth_hs: auth_ready=%b need 1", bus.auth_ready);
      end
      tick();
      bus.auth_valid = 1'b0;
    end
    @(negedge clk);
    n_chk++;
    if (bus.cmd_ready !== 1'b1 || bus.auth_ready !== 1'b0) begin
      n_err++;
      $display("FAIL back_idle: cmd_ready=%b auth_ready=%b need 1 0",
               bus.cmd_ready, bus.auth_ready);
    end
    n_chk++;
    if ({bus.decrypt, bus.hash, bus.proto_err} !==
        {mdl_dec, mdl_hash, 1'b0}) begin
      n_err++;
      $display("FAIL mode_bits: dec,hash,err=%b%b%b need %b%b0",
               bus.decrypt, bus.hash, bus.proto_err, mdl_dec, mdl_hash);
    end
    tick();
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({bus.cmd_ready, bus.key_valid, bus.bdi_valid, bus.auth_ready,
         bus.bdo_ready, bus.proto_err, bus.decrypt, bus.hash,
         bus.key, bus.bdi, bus.bdi_type} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: some output nonzero in reset");
    end
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_idle: cmd_ready=%b need 1", bus.cmd_ready);
    end
    tick();
  endtask

  task automatic test_key();
    rdy_mode = 0;
    run_load(OP_LD_KEY, 4'h0, 16);
  endtask

  task automatic test_ct();
    run_load(OP_DO_DEC, 4'h0, 0);
    run_load(OP_LD_CT, 4'h1, 5);
  endtask

  task automatic test_ad_toggle();
    rdy_mode = 2;
    bus.bdi_ready = 1'b0;
    mirror_chk = 1;
    run_load(OP_LD_AD, 4'h0, 12);
    mirror_chk = 0;
    rdy_mode = 0;
    bus.bdi_ready = 1'b1;
  endtask

  task automatic test_tag();
    run_load(OP_LD_TAG, 4'h1, 16);
  endtask

  task automatic test_boundaries();
    run_load(OP_LD_PT, 4'h1, 0);
    run_load(OP_LD_PT, 4'h1, 1);
    run_load(OP_LD_NONCE, 4'h0, 4);
    run_load(OP_DO_HASH, 4'h0, 7);
    run_load(OP_DO_ENC, 4'h0, 0);
  endtask

  task automatic test_bdo();
    bus.bdo_valid = 1'b1;
    for (int t = 0; t < 6; t++) begin
      bus.bdo_type = 4'(t);
      #1;
      n_chk++;
      if (bus.bdo_ready !== (t == D_TAG || t == D_HASH)) begin
        n_err++;
        $display("FAIL bdo_force: type=%0d got %b", t, bus.bdo_ready);
      end
    end
    bus.bdo_valid = 1'b0;
    bus.bdo_type = D_NULL;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int it = 0; it < 30; it++) begin
      op = 4'($urandom_range(0, 9));
      rdy_mode = int'($urandom_range(0, 1));
      run_load(op, 4'($urandom), int'($urandom_range(0, 20)));
      rdy_mode = 0;
      bus.key_ready = 1'b1;
      bus.bdi_ready = 1'b1;
    end
  endtask

  task automatic test_proto();
    bit ok;
    run_load(OP_DO_DEC, 4'h0, 0);
    bdi_q.delete();
    drive_word(1'b0, $urandom, 5, ok);
    @(negedge clk);
    n_chk++;
    if (!ok || bus.proto_err !== 1'b1 || bdi_q.size() != 0) begin
      n_err++;
      $display("FAIL idle_dat: ok=%b proto_err=%b bdi=%0d need 1 1 0",
               ok, bus.proto_err, bdi_q.size());
    end
    tick();
    drive_word(1'b1, {OP_LD_AD, 4'h0, 24'd8}, 5, ok);
    drive_word(1'b0, $urandom, 5, ok);
    drive_word(1'b1, {OP_LD_AD, 4'h0, 24'd4}, 8, ok);
    n_chk++;
    if (ok || bus.proto_err !== 1'b1 || bdi_q.size() != 1) begin
      n_err++;
      $display("FAIL ins_stall: ok=%b proto_err=%b bdi=%0d need 0 1 1",
               ok, bus.proto_err, bdi_q.size());
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_is_ins = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus.cmd_ready, bus.bdi_valid, bus.decrypt} !== 3'b001) begin
      n_err++;
      $display("FAIL stall_state: rdy,bdi_valid,dec=%b%b%b need 001",
               bus.cmd_ready, bus.bdi_valid, bus.decrypt);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({bus.cmd_ready, bus.key_valid, bus.bdi_valid, bus.auth_ready,
         bus.bdo_ready, bus.proto_err, bus.decrypt, bus.hash,
         bus.bdi_eot, bus.bdi_eoi, bus.key, bus.bdi,
         bus.bdi_type} !== '0) begin
      n_err++;
      $display("FAIL async_rst: outputs not cleared, err=%b dec=%b",
               bus.proto_err, bus.decrypt);
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_is_ins = 1'b0;
    mdl_dec = 0;
    mdl_hash = 0;
    tick();
    rst = 1'b0;
    run_load(OP_LD_NONCE, 4'h0, 8);
  endtask

  initial begin
    bus.cmd_data = '0;
    bus.cmd_is_ins = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.key_ready = 1'b1;
    bus.bdi_ready = 1'b1;
    bus.bdo_valid = 1'b0;
    bus.bdo_type = D_NULL;
    bus.auth_valid = 1'b0;
    test_reset();
    test_key();
    test_ct();
    test_ad_toggle();
    test_tag();
    test_boundaries();
    test_bdo();
    test_random();
    test_proto();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ascon_cmd_sequencer.md
Name: ascon_cmd_sequencer

Overview:
Hardware front end that feeds ascon_core from a 32-bit command stream of INS/DAT words, the same format as the tv.txt vectors. It decodes each instruction word into op, flags and byte length, then forwards the following data words onto the core's key or bdi interface with the correct bdi_type, bdi_eot and bdi_eoi. It also drives the persistent decrypt/hash mode bits and the bdo_ready/auth_ready sink signals. It sits directly upstream of ascon_core, fed by a UART/FIFO or by a bench.

Parameters:
LEN_W, 24, width of the byte-length field in an instruction word (bits [LEN_W-1:0])
CNT_W, 22, width of the remaining-words counter (must be >= LEN_W-2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cmd_data  in  32  command word; INS: [31:28]=op, [27:24]=flags, [23:0]=byte length; DAT: payload
cmd_is_ins  in  1  1 = instruction word, 0 = data word
cmd_valid  in  1  command word valid
cmd_ready  out  1  command word accepted this cycle
key  out  CCSW  key word to core
key_valid  out  1  key word valid
key_ready  in  1  core accepts key
bdi  out  CCW  block data to core
bdi_valid  out  1  bdi valid
bdi_ready  in  1  core accepts bdi
bdi_type  out  4  D_NONCE/D_AD/D_PTCT/D_TAG/D_NULL
bdi_eot  out  1  last word of this type
bdi_eoi  out  1  last input word overall (flags[0] on last word)
decrypt  out  1  persistent mode bit
hash  out  1  persistent mode bit
bdo_valid  in  1  core output valid
bdo_type  in  4  core output type
bdo_ready  out  1  sink ready for core output
auth_valid  in  1  tag verification result valid
auth_ready  out  1  sink ready for verification result
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset values: state=IDLE, cnt=0, op=OP_NOP-equivalent (0), decrypt=0, hash=0, proto_err=0. All valid/ready outputs are 0. key, bdi and bdi_type are driven to 0/D_NULL.
- Reset is async. Asserting it mid-transfer aborts immediately; partially sent words are not replayed.
- States: IDLE, KEY, BDI, WAIT_AUTH.
- IDLE:
  - cmd_ready=1. On INS handshake, latch op and flags, and set cnt = ceil(len/4) = (len+3)>>2, truncated to CNT_W.
  - OP_LD_KEY with cnt>0 -> KEY.
  - OP_LD_NONCE/AD/PT/CT/TAG with cnt>0 -> BDI.
  - OP_DO_ENC: decrypt<=0, hash<=0. OP_DO_DEC: decrypt<=1, hash<=0. OP_DO_HASH: decrypt<=0, hash<=1. Stay in IDLE.
  - Length 0 on a load op: no words are issued; stay in IDLE.
  - DAT word in IDLE: consumed and dropped; proto_err<=1.
- KEY:
  - Zero-latency pass-through: key=cmd_data, key_valid=cmd_valid&!cmd_is_ins, cmd_ready=key_ready&!cmd_is_ins.
  - Each handshake decrements cnt. At cnt==1 handshake -> IDLE.
- BDI:
  - Same pass-through to bdi/bdi_valid/bdi_ready.
  - bdi_type is taken from the op: NONCE->D_NONCE, AD->D_AD, PT/CT->D_PTCT, TAG->D_TAG.
  - bdi_eot=(cnt==1). bdi_eoi=(cnt==1)&flags[0].
  - bdo_ready=1 while op is PT or CT.
  - Last handshake: OP_LD_TAG -> WAIT_AUTH; otherwise -> IDLE.
- INS word arriving in KEY or BDI: cmd_ready=0 (stalls), proto_err<=1, nothing is forwarded. Only reset recovers.
- WAIT_AUTH: cmd_ready=0, auth_ready=1. The cycle auth_valid is seen -> IDLE.
- bdo_ready is also forced to 1 in any state when bdo_valid & bdo_type is D_TAG or D_HASH.
- Decrement arithmetic never underflows; cnt saturates at 0.

Optional Feature:
- ASCON_SEQ_STATS_EN defined: adds outputs stat_ins[15:0] (INS handshakes) and stat_dat[15:0] (forwarded DAT handshakes). Both are wrapping counters, reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- OP_* opcodes, D_* types, CCW and CCSW stay in the existing shared config (config_core.vh / core package).
- seq_state_t enum and a function op2bdi_type(op) go in that package.
- No sub-module needed; the stats counters form an optional small sub-module, ascon_seq_stats.

Test Plan:
- INS {OP_LD_KEY,0,16} + 4 DAT words with key_ready=1 -> key_valid pulses 4 cycles, cmd_ready 4x, state back to IDLE, no bdi_valid.
- INS {OP_DO_DEC}, then INS {OP_LD_CT,flags=1,len=5} + 2 DAT -> decrypt=1, hash=0, bdi_type=D_PTCT on both words, bdi_eot=bdi_eoi=1 on second word only, bdo_ready=1 during phase.
- INS {OP_LD_AD,len=12} + 3 DAT with bdi_ready toggling 1,0,1,0,1 -> exactly 3 transfers, cmd_ready mirrors bdi_ready, eot on third word, eoi=0.
- INS {OP_LD_TAG,flags=1,len=16} + 4 DAT, auth_valid asserted 3 cycles later -> auth_ready high from last word until auth_valid, then IDLE accepts next INS.
- DAT word in IDLE, then INS inside a BDI phase -> proto_err=1 sticky, INS not accepted until rst; async rst mid-phase clears every output in the same cycle.
- bdo_valid=1 with bdo_type=D_HASH while in IDLE -> bdo_ready=1 combinationally.
